// File: rtl/fir_serializer_pkg.sv
// Shared definitions for the FIR serializer: default word length and FSM state encoding.
package fir_serializer_pkg;

    localparam int FIR_LENGTH = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/fir_serializer_if.sv
// Word-side handshake from the FIR core plus the bit-side stream to the sink.
interface fir_serializer_if #(
    parameter int LENGTH = fir_serializer_pkg::FIR_LENGTH
);
    logic [LENGTH-1:0] iv_din;
    logic              i_din_valid;
    logic              o_ready;
    logic              i_ready;
    logic              o_dout;
    logic              o_dout_valid;
    logic              o_frame;

    modport master (
        output iv_din, i_din_valid, i_ready,
        input  o_ready, o_dout, o_dout_valid, o_frame
    );

    modport slave (
        input  iv_din, i_din_valid, i_ready,
        output o_ready, o_dout, o_dout_valid, o_frame
    );
endinterface

// File: rtl/ser_hold_reg.sv
// One-entry data register with a full flag; load fills it, take empties it.
module ser_hold_reg #(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] iv_data,
    input  logic             i_take,
    output logic [WIDTH-1:0] ov_data,
    output logic             o_full
);
    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Load only happens when empty and take only when full, so they never collide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= {WIDTH{1'b0}};
            r_full <= 1'b0;
        end else if (i_take) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= iv_data;
            r_full <= 1'b1;
        end else begin
            r_full <= r_full;
        end
    end

    assign ov_data = r_data;
    assign o_full  = r_full;
endmodule

// File: rtl/fir_serializer.sv
// Parallel-to-serial transmitter: LSB first, one bit per qualified strobe, frame marker on bit 0.
module fir_serializer
    import fir_serializer_pkg::*;
#(
    parameter int LENGTH = FIR_LENGTH,
    parameter int CNT_W  = $clog2(LENGTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    output logic              o_busy,
    fir_serializer_if.slave   bus
);
    ser_state_e        r_state;
    logic [LENGTH-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dout;
    logic              r_dout_valid;
    logic              r_frame;

    logic [LENGTH-1:0] w_hold;
    logic              w_hold_full;
    logic              w_accept;
    logic              w_stb;
    logic              w_last;
    logic              w_take;

    assign bus.o_ready = ~w_hold_full & ~i_rst;
    assign w_accept    = bus.i_din_valid & bus.o_ready;
    assign w_stb       = i_en & bus.i_ready & (r_state == ST_SHIFT);
    assign w_last      = (r_cnt == CNT_W'(LENGTH - 1));
    // The hold empties on an idle load or on a back-to-back reload at the last bit.
    assign w_take      = w_hold_full & ((r_state == ST_IDLE) | (w_stb & w_last));

    ser_hold_reg #(
        .WIDTH (LENGTH)
    ) u_hold (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_accept),
        .iv_data (bus.iv_din),
        .i_take  (w_take),
        .ov_data (w_hold),
        .o_full  (w_hold_full)
    );

    // Shift FSM: load from the hold, then emit one bit per strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= {LENGTH{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_frame      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dout_valid <= 1'b0;
                    r_frame      <= 1'b0;
                    if (w_hold_full) begin
                        r_shift <= w_hold;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_stb) begin
                        r_dout       <= r_shift[0];
                        r_dout_valid <= 1'b1;
                        r_frame      <= (r_cnt == {CNT_W{1'b0}});
                        if (!w_last) begin
                            r_shift <= r_shift >> 1;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end else if (w_hold_full) begin
                            r_shift <= w_hold;
                            r_cnt   <= {CNT_W{1'b0}};
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_cnt   <= {CNT_W{1'b0}};
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_dout_valid <= 1'b0;
                        r_frame      <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_dout_valid <= 1'b0;
                    r_frame      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_dout       = r_dout;
    assign bus.o_dout_valid = r_dout_valid;
    assign bus.o_frame      = r_frame;
    assign o_busy           = (r_state == ST_SHIFT) | w_hold_full;
endmodule
